hdcpu_irq_ctrl: RTL
===================

// Module: hdcpu_irq_ctrl
// PURPOSE
//  Second-generation hardwired controller for the 8-bit teaching CPU.
//  - Generates its own W1..W3 beat sequence.
//  - Decodes the console switch modes and run-mode opcodes into datapath strobes.
//  - Adds prioritised multi-source interrupts with a nested PC/flag save stack (LIFO).
//  Sits between the console/IR and the datapath. Drives every control strobe.
// PARAMETERS
//  DW          8      PC/data width
//  NIRQ        4      interrupt request lines
//  NEST        2      save-stack depth (max nested interrupts)
//  VEC_BASE    8'hF0  first interrupt vector address
//  VEC_STRIDE  4      address step between vectors
// PORTS
//  T3        in   1     clock, rising edge
//  CLR       in   1     reset, synchronous, active low
//  SW        in   3     console mode
//  IR        in   8     instruction register ([7:4] opcode)
//  C, Z      in   1     datapath flags
//  STEP      in   1     advance one beat while STOP is asserted
//  IRQ       in   NIRQ  level-sensitive requests; index 0 has highest priority
//  PC_IN     in   DW    current PC, for save
//  W         out  3     one-hot beat {W3,W2,W1}
//  LDC,LDZ,CIN,M,ABUS,DRW,PCINC,LPC,LAR,PCADD,ARINC,SELCTL,MEMW,STOP,LIR,SBUS,MBUS,SHORT,LONG
//            out  1     datapath strobes, one bit each
//  S, SEL    out  4     ALU function; register select
//  PC_OUT    out  DW    PC value to load when LPC_EXT=1
//  LPC_EXT   out  1     load PC from PC_OUT
//  CZ_OUT    out  2     {C,Z} to restore; LDCZ_EXT loads them
//  LDCZ_EXT  out  1     load {C,Z} from CZ_OUT
//  IACK      out  NIRQ  one-hot acknowledge, asserted for one beat
//  EI        out  1     interrupt enable
//  ERR       out  2     sticky flags {stack overflow, IRET underflow}
// BEHAVIOUR
//  Timing
//  - Registered state: W, ST0, SW_q, EI, ERR, stack.
//  - All strobes, IACK and PC_OUT are combinational decodes of registered state + inputs.
//  Reset (CLR=0 sampled at T3)
//  - W=001, ST0=0, EI=1, stack empty, ERR=00, SW_q=SW.
//  - While CLR=0 every strobe, S, SEL, PC_OUT, CZ_OUT and IACK is forced to 0.
//  - Reset mid-instruction abandons the instruction; nothing is saved.
//  Beat sequencer
//  - After W1: stay W1 if SHORT, else W2.
//  - After W2: go to W3 if LONG, else W1.
//  - After W3: go to W1.
//  - STOP=1 freezes W and ST0 unless STEP=1, which allows exactly one advance.
//  SW change (SW!=SW_q)
//  - Next edge: W=001, ST0=0, SW_q=SW.
//  - Takes precedence over all activity except reset.
//  Console modes
//  - 001 ST0=0 W1: SBUS,LAR,SELCTL,STOP,SHORT; set ST0.
//  - 001 ST0=1 W1: SBUS,MEMW,ARINC,SELCTL,STOP,SHORT.
//  - 010 ST0=0 W1: SBUS,LAR,SELCTL,STOP,SHORT; set ST0.
//  - 010 ST0=1 W1: MBUS,ARINC,SELCTL,STOP,SHORT.
//  - 011 W1: SEL=0001. 011 W2: SEL=1011. SELCTL and STOP asserted on both beats.
//  - 100: SBUS,SELCTL,DRW,STOP on W1/W2.
//      ST0=0: W1 SEL=0011, W2 SEL=0110, set ST0.
//      ST0=1: W1 SEL=1001, W2 SEL=1110, then clear ST0.
//  - 000 ST0=0 W1: SBUS,LPC,SHORT,STOP; set ST0. ST0=1 is run mode.
//  Run mode, W1
//  - Fetch: LIR, PCINC.
//  - Exception: interrupt entry replaces the fetch when EI=1, IRQ!=0 and STOP=0.
//  Interrupt entry (one SHORT beat)
//  - idx = lowest set IRQ bit; IACK[idx]=1.
//  - Push {PC_IN,C,Z}; EI<=0.
//  - LPC_EXT=1, PC_OUT=VEC_BASE+idx*VEC_STRIDE (mod 2^DW).
//  - Stack full: no entry, normal fetch, ERR[1]<=1.
//  Run mode, W2/W3 (ALU codes per package)
//  - ADD/SUB/AND/INC/OR/XOR, W2: ABUS,DRW,LDZ. LDC for arithmetic ops only.
//  - LD: W2 ABUS,LAR,LONG. W3 MBUS,DRW.
//  - ST: W2 ABUS,LAR,LONG. W3 ABUS,MEMW.
//  - JC/JZ: W2 PCADD only if C/Z is 1.
//  - JMP: W2 ABUS,LPC.
//  - OUT: W2 ABUS.
//  - STP: W2 STOP.
//  - EI/DI (1111): W2 EI<=IR[0].
//  - IRET (1011), W2, stack non-empty: pop; PC_OUT=saved PC; LPC_EXT=1; CZ_OUT=saved {C,Z}; LDCZ_EXT=1; EI<=1.
//  - IRET, W2, stack empty: behaves as NOP; ERR[0]<=1.
//  Precedence
//  - IRQ asserting during IRET is not taken until the next fetch W1, after the pop.
//  - IRQ during STOP is held off until STOP is released.
// STRUCTURE
//  - hdcpu_pkg: opcode localparams, SW mode codes, ALU {S,M,CIN} constants, beat encodings.
//  - Sub-module hdcpu_irq_stack: LIFO, width DW+2, depth NEST; push/pop/full/empty.
//      Push on full and pop on empty are ignored.
// TESTING
//  - Reset: CLR=0 with SW=000 -> W=001, EI=1, all strobes 0; CLR=1 -> W1 shows SBUS,LPC,SHORT,STOP.
//  - Console: SW=001 with STEP pulses -> LAR on first W1, then MEMW+ARINC on each later W1.
//      Switch SW to 010 mid-sequence -> ST0=0 next edge.
//  - Run: LD opcode 0101 -> W1, W2 (LAR, LONG), W3 (MBUS, DRW) -> W1.
//      JC with C=0 -> no PCADD.
//  - IRQ: IRQ=4'b0110, EI=1, PC_IN=8'h23 -> IACK=0010, PC_OUT=8'hF4, EI=0.
//      Following IRET -> PC_OUT=8'h23, flags restored, EI=1.
//  - Nesting: EI re-enabled in handler, second IRQ taken (depth 2); third IRQ -> ERR[1]=1, no IACK.
//      IRET with empty stack -> ERR[0]=1.
//  - Reset mid-handler: CLR=0 during W2 -> stack empty, EI=1, ERR=00.

Source files
------------

// File: rtl/hdcpu_pkg.sv
// Shared encodings for the hardwired teaching-CPU controller:
// beats, console modes, opcodes, ALU settings and the strobe bundle.
package hdcpu_pkg;

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_t;

    localparam logic [2:0] SW_RUN  = 3'b000;
    localparam logic [2:0] SW_WMEM = 3'b001;
    localparam logic [2:0] SW_RMEM = 3'b010;
    localparam logic [2:0] SW_RREG = 3'b011;
    localparam logic [2:0] SW_WREG = 3'b100;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_LD   = 4'b0101;
    localparam logic [3:0] OP_ST   = 4'b0110;
    localparam logic [3:0] OP_JC   = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_OUT  = 4'b1010;
    localparam logic [3:0] OP_IRET = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_STP  = 4'b1110;
    localparam logic [3:0] OP_EIDI = 4'b1111;

    // 74181-style ALU setting; CIN is active low on the datapath.
    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       cin;
    } alu_t;

    localparam alu_t ALU_ADD = '{s: 4'b1001, m: 1'b0, cin: 1'b1};
    localparam alu_t ALU_SUB = '{s: 4'b0110, m: 1'b0, cin: 1'b0};
    localparam alu_t ALU_AND = '{s: 4'b1011, m: 1'b1, cin: 1'b0};
    localparam alu_t ALU_INC = '{s: 4'b0000, m: 1'b0, cin: 1'b0};
    localparam alu_t ALU_OR  = '{s: 4'b1110, m: 1'b1, cin: 1'b0};
    localparam alu_t ALU_XOR = '{s: 4'b0110, m: 1'b1, cin: 1'b0};

    typedef struct packed {
        logic ldc, ldz, cin, m, abus, drw, pcinc, lpc, lar, pcadd;
        logic arinc, selctl, memw, stop, lir, sbus, mbus, short_beat, long_beat;
        logic [3:0] s;
        logic [3:0] sel;
    } ctrl_t;

    function automatic beat_t next_beat(beat_t w, logic short_beat, logic long_beat);
        case (w)
            BEAT_W1: return short_beat ? BEAT_W1 : BEAT_W2;
            BEAT_W2: return long_beat ? BEAT_W3 : BEAT_W1;
            BEAT_W3: return BEAT_W1;
            default: return BEAT_W1;
        endcase
    endfunction

endpackage

// File: rtl/hdcpu_irq_stack.sv
// LIFO holding {PC, C, Z} for each nested interrupt; push on full and
// pop on empty are ignored, and the top entry is visible combinationally.
module hdcpu_irq_stack #(
    parameter int unsigned W    = 10,
    parameter int unsigned NEST = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CW = $clog2(NEST + 1);
    localparam int unsigned AW = (NEST > 1) ? $clog2(NEST) : 1;

    logic [W-1:0]  mem [NEST];
    logic [CW-1:0] count;

    assign full  = (count == CW'(NEST));
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[AW'(count - CW'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (push && !full)
            count <= count + CW'(1);
        else if (pop && !empty)
            count <= count - CW'(1);
    end

    // NOTE: only the occupancy count is reset; entries above it are never read, so the array needs none.
    always_ff @(posedge clk) begin
        if (rst_n && push && !full)
            mem[AW'(count)] <= din;
    end

endmodule

// File: rtl/hdcpu_irq_ctrl.sv
// Hardwired controller for the 8-bit teaching CPU: beat sequencer, console
// and run-mode decode, and prioritised nested interrupts with a save stack.
module hdcpu_irq_ctrl
    import hdcpu_pkg::*;
#(
    parameter int unsigned    DW         = 8,
    parameter int unsigned    NIRQ       = 4,
    parameter int unsigned    NEST       = 2,
    parameter logic [DW-1:0]  VEC_BASE   = 8'hF0,
    parameter int unsigned    VEC_STRIDE = 4
) (
    input  logic            T3,
    input  logic            CLR,
    input  logic [2:0]      SW,
    input  logic [7:0]      IR,
    input  logic            C,
    input  logic            Z,
    input  logic            STEP,
    input  logic [NIRQ-1:0] IRQ,
    input  logic [DW-1:0]   PC_IN,
    output logic [2:0]      W,
    output logic            LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD,
    output logic            ARINC, SELCTL, MEMW, STOP, LIR, SBUS, MBUS, SHORT, LONG,
    output logic [3:0]      S,
    output logic [3:0]      SEL,
    output logic [DW-1:0]   PC_OUT,
    output logic            LPC_EXT,
    output logic [1:0]      CZ_OUT,
    output logic            LDCZ_EXT,
    output logic [NIRQ-1:0] IACK,
    output logic            EI,
    output logic [1:0]      ERR
);

    beat_t           w_q, w_d;
    logic            st0_q, st0_d;
    logic [2:0]      sw_q;
    logic            ei_q, ei_d;
    logic [1:0]      err_q, err_d;
    logic            sw_chg, live, adv;
    logic            push_req, pop_req;
    logic            stk_full, stk_empty;
    logic [DW+1:0]   stk_top;
    ctrl_t           ctrl, ctrl_o;
    logic [NIRQ-1:0] irq_first, iack_d;
    logic [DW-1:0]   pc_out_d;
    logic [1:0]      cz_out_d;
    logic            lpc_ext_d, ldcz_ext_d;
    logic            irq_hit;
    int              irq_idx;
    alu_t            alu;
    logic            alu_arith;
    logic            unused_ir_bits;

    assign unused_ir_bits = ^IR[3:1];
    assign sw_chg    = (SW != sw_q);
    assign live      = CLR && !sw_chg;
    assign irq_hit   = |IRQ;
    assign irq_first = IRQ & (~IRQ + NIRQ'(1));

    always_comb begin
        irq_idx = 0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (IRQ[i])
                irq_idx = i;
        end
    end

    always_comb begin
        alu       = '0;
        alu_arith = 1'b0;
        case (IR[7:4])
            OP_ADD:  begin alu = ALU_ADD; alu_arith = 1'b1; end
            OP_SUB:  begin alu = ALU_SUB; alu_arith = 1'b1; end
            OP_INC:  begin alu = ALU_INC; alu_arith = 1'b1; end
            OP_AND:  alu = ALU_AND;
            OP_OR:   alu = ALU_OR;
            OP_XOR:  alu = ALU_XOR;
            default: alu = '0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        ctrl       = '0;
        iack_d     = '0;
        pc_out_d   = '0;
        cz_out_d   = '0;
        lpc_ext_d  = 1'b0;
        ldcz_ext_d = 1'b0;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        st0_d      = st0_q;
        ei_d       = ei_q;
        err_d      = err_q;

        case (sw_q)
            SW_RUN: begin
                if (!st0_q) begin
                    if (w_q == BEAT_W1) begin
                        ctrl.sbus = 1'b1; ctrl.lpc = 1'b1; ctrl.short_beat = 1'b1; ctrl.stop = 1'b1;
                        st0_d = 1'b1;
                    end
                end else begin
                    case (w_q)
                        BEAT_W1: begin
                            if (ei_q && irq_hit && !stk_full) begin
                                iack_d = irq_first;
                                push_req = 1'b1;
                                ei_d = 1'b0;
                                lpc_ext_d = 1'b1;
                                pc_out_d = VEC_BASE + DW'(irq_idx * VEC_STRIDE);
                                ctrl.short_beat = 1'b1;
                            end else begin
                                ctrl.lir = 1'b1; ctrl.pcinc = 1'b1;
                                if (ei_q && irq_hit)
                                    err_d[1] = 1'b1;
                            end
                        end
                        BEAT_W2: begin
                            case (IR[7:4])
                                OP_ADD, OP_SUB, OP_AND, OP_INC, OP_OR, OP_XOR: begin
                                    ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1;
                                    ctrl.ldc = alu_arith;
                                    ctrl.s = alu.s; ctrl.m = alu.m; ctrl.cin = alu.cin;
                                end
                                OP_LD, OP_ST: begin
                                    ctrl.abus = 1'b1; ctrl.lar = 1'b1; ctrl.long_beat = 1'b1;
                                end
                                OP_JC:   ctrl.pcadd = C;
                                OP_JZ:   ctrl.pcadd = Z;
                                OP_JMP:  begin ctrl.abus = 1'b1; ctrl.lpc = 1'b1; end
                                OP_OUT:  ctrl.abus = 1'b1;
                                OP_STP:  ctrl.stop = 1'b1;
                                OP_EIDI: ei_d = IR[0];
                                OP_IRET: begin
                                    if (!stk_empty) begin
                                        pop_req = 1'b1;
                                        pc_out_d = stk_top[DW+1:2];
                                        cz_out_d = stk_top[1:0];
                                        lpc_ext_d = 1'b1;
                                        ldcz_ext_d = 1'b1;
                                        ei_d = 1'b1;
                                    end else begin
                                        err_d[0] = 1'b1;
                                    end
                                end
                                OP_NOP:  ;
                                default: ;
                            endcase
                        end
                        BEAT_W3: begin
                            if (IR[7:4] == OP_LD) begin
                                ctrl.mbus = 1'b1; ctrl.drw = 1'b1;
                            end else if (IR[7:4] == OP_ST) begin
                                ctrl.abus = 1'b1; ctrl.memw = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SW_WMEM, SW_RMEM: begin
                if (w_q == BEAT_W1) begin
                    ctrl.selctl = 1'b1; ctrl.stop = 1'b1; ctrl.short_beat = 1'b1;
                    if (!st0_q) begin
                        ctrl.sbus = 1'b1; ctrl.lar = 1'b1;
                        st0_d = 1'b1;
                    end else if (sw_q == SW_WMEM) begin
                        ctrl.sbus = 1'b1; ctrl.memw = 1'b1; ctrl.arinc = 1'b1;
                    end else begin
                        ctrl.mbus = 1'b1; ctrl.arinc = 1'b1;
                    end
                end
            end
            SW_RREG: begin
                if (w_q != BEAT_W3) begin
                    ctrl.selctl = 1'b1; ctrl.stop = 1'b1;
                    ctrl.sel = (w_q == BEAT_W1) ? 4'b0001 : 4'b1011;
                end
            end
            SW_WREG: begin
                if (w_q != BEAT_W3) begin
                    ctrl.sbus = 1'b1; ctrl.selctl = 1'b1; ctrl.drw = 1'b1; ctrl.stop = 1'b1;
                    if (w_q == BEAT_W1)
                        ctrl.sel = st0_q ? 4'b1001 : 4'b0011;
                    else begin
                        ctrl.sel = st0_q ? 4'b1110 : 4'b0110;
                        st0_d = !st0_q;
                    end
                end
            end
            default: ;
        endcase

        // STOP freezes the beat and ST0; STEP lets exactly one advance through.
        adv = !ctrl.stop || STEP;
        w_d = adv ? next_beat(w_q, ctrl.short_beat, ctrl.long_beat) : w_q;
        if (!adv)
            st0_d = st0_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge T3) begin
        if (!CLR) begin
            w_q   <= BEAT_W1;
            st0_q <= 1'b0;
            sw_q  <= SW;
            ei_q  <= 1'b1;
            err_q <= '0;
        end else if (sw_chg) begin
            w_q   <= BEAT_W1;
            st0_q <= 1'b0;
            sw_q  <= SW;
        end else begin
            w_q   <= w_d;
            st0_q <= st0_d;
            ei_q  <= ei_d;
            err_q <= err_d;
        end
    end

    hdcpu_irq_stack #(.W(DW + 2), .NEST(NEST)) u_stack (
        .clk   (T3),
        .rst_n (CLR),
        .push  (push_req && live),
        .pop   (pop_req && live),
        .din   ({PC_IN, C, Z}),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign ctrl_o = CLR ? ctrl : '0;

    assign {LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD} =
           {ctrl_o.ldc, ctrl_o.ldz, ctrl_o.cin, ctrl_o.m, ctrl_o.abus, ctrl_o.drw,
            ctrl_o.pcinc, ctrl_o.lpc, ctrl_o.lar, ctrl_o.pcadd};
    assign {ARINC, SELCTL, MEMW, STOP, LIR, SBUS, MBUS, SHORT, LONG} =
           {ctrl_o.arinc, ctrl_o.selctl, ctrl_o.memw, ctrl_o.stop, ctrl_o.lir,
            ctrl_o.sbus, ctrl_o.mbus, ctrl_o.short_beat, ctrl_o.long_beat};
    assign S        = ctrl_o.s;
    assign SEL      = ctrl_o.sel;
    assign IACK     = CLR ? iack_d : '0;
    assign PC_OUT   = CLR ? pc_out_d : '0;
    assign CZ_OUT   = CLR ? cz_out_d : '0;
    assign LPC_EXT  = CLR && lpc_ext_d;
    assign LDCZ_EXT = CLR && ldcz_ext_d;
    assign W        = w_q;
    assign EI       = ei_q;
    assign ERR      = err_q;

endmodule
